axil_timer: RTL and testbench

AXI-Lite responder holding a free-running 32-bit timer with a compare match and a level interrupt output. It sits as an extra slave port on the SoC AXI-Lite interconnect, clocked from the CPU/pixel clock. Its `irq` drives one bit of the picorv32 `irq` vector. It is the register-mapped counterpart the CPU needs for periodic ticks, frame pacing and timeouts.

---
 rtl/axil_timer_pkg.sv | 41 ++++
 rtl/axil_timer_prescaler.sv | 30 +++
 rtl/axil_timer.sv | 202 ++++++++++++++++++++
 tb/tb_axil_timer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_timer_pkg.sv
// Shared constants and types for the AXI-Lite timer: register offsets, CTRL bit
// positions, response codes and the read/write channel state encodings.
package axil_timer_pkg;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_COUNT    = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IEN    = 2;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_timer_prescaler.sv
// Tick divider: counts 0..PRESCALE while enabled and pulses tick on the terminal value.
// Only present when AXIL_TIMER_PRESCALER_EN is defined.
`ifdef AXIL_TIMER_PRESCALER_EN
module axil_timer_prescaler (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic [31:0] prescale_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (tick_o) cnt_d = '0;
        else if (en_i)   cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule
`endif

// File: rtl/axil_timer.sv
// AXI-Lite slave with a free-running 32-bit timer, compare match and level irq.
// AXIL_TIMER_PRESCALER_EN adds the PRESCALE register at 0x10 and the tick divider.
//   state   | meaning
//   WR_IDLE | waiting for AW and W together; write commits on the accepting edge
//   WR_RESP | bvalid held until bready
//   RD_IDLE | arready high; read data captured on the accepting edge
//   RD_DATA | rvalid held until rready
module axil_timer
    import axil_timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  irq
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    resp_t       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        pending_q, pending_d;
    logic        wr_en, tick, match;
    logic [2:0]  wr_idx, rd_idx;
    logic        unused_bits;

    assign wr_idx = s_axil_awaddr[4:2];
    assign rd_idx = s_axil_araddr[4:2];
    assign unused_bits = ^{s_axil_awaddr[ADDR_WIDTH-1:5], s_axil_awaddr[1:0], s_axil_awprot,
                           s_axil_araddr[ADDR_WIDTH-1:5], s_axil_araddr[1:0], s_axil_arprot};

    function automatic logic is_mapped(input logic [2:0] idx);
        case (idx)
            IDX_CTRL, IDX_COUNT, IDX_COMPARE, IDX_STATUS: return 1'b1;
`ifdef AXIL_TIMER_PRESCALER_EN
            IDX_PRESCALE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

`ifdef AXIL_TIMER_PRESCALER_EN
    logic [31:0] prescale_q, prescale_d;
    logic        wr_prescale;

    assign wr_prescale = wr_en && (wr_idx == IDX_PRESCALE);
    assign prescale_d  = wr_prescale ? apply_strb(prescale_q, s_axil_wdata, s_axil_wstrb) : prescale_q;

    axil_timer_prescaler u_prescaler (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .en_i       (ctrl_q[CTRL_EN]),
        .clear_i    (wr_prescale),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );
`else
    assign tick = ctrl_q[CTRL_EN];
`endif

    assign match = tick && (count_q == compare_q);
    assign irq   = pending_q & ctrl_q[CTRL_IEN];

    always_comb begin
        wr_state_d     = wr_state_q;
        bresp_d        = bresp_q;
        wr_en          = 1'b0;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aresetn && s_axil_awvalid && s_axil_wvalid) begin
                    s_axil_awready = 1'b1;
                    s_axil_wready  = 1'b1;
                    wr_en          = 1'b1;
                    bresp_d        = is_mapped(wr_idx) ? OKAY : SLVERR;
                    wr_state_d     = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            IDX_CTRL:    rd_val = {29'd0, ctrl_q};
            IDX_COUNT:   rd_val = count_q;
            IDX_COMPARE: rd_val = compare_q;
            IDX_STATUS:  rd_val = {31'd0, pending_q};
`ifdef AXIL_TIMER_PRESCALER_EN
            IDX_PRESCALE: rd_val = prescale_q;
`endif
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        rd_state_d     = rd_state_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                s_axil_arready = aresetn;
                if (aresetn && s_axil_arvalid) begin
                    rdata_d    = rd_val;
                    rresp_d    = is_mapped(rd_idx) ? OKAY : SLVERR;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Software writes to COUNT win over the tick; a match beats a same-cycle W1C.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        pending_d = pending_q;
        if (wr_en && wr_idx == IDX_CTRL && s_axil_wstrb[0]) ctrl_d = s_axil_wdata[2:0];
        if (wr_en && wr_idx == IDX_COMPARE)
            compare_d = apply_strb(compare_q, s_axil_wdata, s_axil_wstrb);
        if (wr_en && wr_idx == IDX_COUNT)
            count_d = apply_strb(count_q, s_axil_wdata, s_axil_wstrb);
        else if (tick)
            count_d = (match && ctrl_q[CTRL_RELOAD]) ? 32'd0 : count_q + 32'd1;
        if (match)
            pending_d = 1'b1;
        else if (wr_en && wr_idx == IDX_STATUS && s_axil_wstrb[0] && s_axil_wdata[0])
            pending_d = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            bresp_q    <= OKAY;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            pending_q  <= 1'b0;
`ifdef AXIL_TIMER_PRESCALER_EN
            prescale_q <= '0;
`endif
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            pending_q  <= pending_d;
`ifdef AXIL_TIMER_PRESCALER_EN
            prescale_q <= prescale_d;
`endif
        end
    end

    assign s_axil_bresp = bresp_q;
    assign s_axil_rresp = rresp_q;
    assign s_axil_rdata = rdata_q;

endmodule

// File: tb/tb_axil_timer.sv
// Self-checking bench for axil_timer; expected counter values come from tick arithmetic
// relative to the edge that enabled the timer.
module tb_axil_timer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [31:0] s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b1;
    logic        irq;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [31:0] compare_model = '0;

    axil_timer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .irq(irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Bus helpers: called on a falling edge, return on a falling edge; acc is the
    // value cyc takes after the accepting rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int acc, output logic irq_s);
        int n;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1;
        n = 0;
        while (!(s_axil_awready && s_axil_wready) && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL wr_accept_timeout awready=%b required 1", s_axil_awready); end
        acc = cyc + 1;
        @(negedge aclk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        #1;
        n = 0;
        while (!s_axil_bvalid && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL wr_bvalid_timeout bvalid=%b required 1", s_axil_bvalid); end
        resp = s_axil_bresp;
        irq_s = irq;
        @(negedge aclk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int acc);
        int n;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axil_arready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL rd_accept_timeout arready=%b required 1", s_axil_arready); end
        acc = cyc + 1;
        @(negedge aclk);
        s_axil_arvalid = 1'b0;
        #1;
        n = 0;
        while (!s_axil_rvalid && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL rd_rvalid_timeout rvalid=%b required 1", s_axil_rvalid); end
        data = s_axil_rdata;
        resp = s_axil_rresp;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int a;
        aresetn = 1'b0;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        repeat (2) @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_axil_bvalid !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b want 0", s_axil_bvalid); end
            checks++; if (s_axil_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want 0", s_axil_rvalid); end
            checks++; if (s_axil_awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b want 0", s_axil_awready); end
            checks++; if (s_axil_arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b want 0", s_axil_arready); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want 0", irq); end
            @(negedge aclk);
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        axi_read(32'h00, d, r, a);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl_rdata got=%h want 0", d); end
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL reset_ctrl_rresp got=%b want 00", r); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after got=%b want 0", irq); end
    endtask

    task automatic test_strobes();
        logic [31:0] d, v; logic [1:0] r; logic [3:0] s; int a; logic q;
        axi_write(32'h08, 32'h12345678, 4'hF, r, a, q);
        axi_write(32'h08, 32'hAABBCCDD, 4'h1, r, a, q);
        compare_model = 32'h123456DD;
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL strb_bresp got=%b want 00", r); end
        axi_read(32'h08, d, r, a);
        checks++; if (d !== 32'h123456DD) begin failures++; $display("FAIL strb_byte0 got=%h want 123456dd", d); end
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            s = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) if (s[b]) compare_model[8*b +: 8] = v[8*b +: 8];
            axi_write(32'h08, v, s, r, a, q);
            axi_read(32'h08, d, r, a);
            checks++; if (d !== compare_model) begin failures++; $display("FAIL strb_random strb=%b got=%h want %h", s, d, compare_model); end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; int a; logic q;
        axi_read(32'h1C, d, r, a);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rd_data got=%h want 0", d); end
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL unmapped_rd_resp got=%b want 10", r); end
        axi_write(32'h18, $urandom, 4'hF, r, a, q);
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL unmapped_wr_resp got=%b want 10", r); end
        axi_read(32'h00, d, r, a);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_ctrl got=%h want 0", d); end
        axi_read(32'h04, d, r, a);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_count got=%h want 0", d); end
        axi_read(32'h28, d, r, a);
        checks++; if (d !== compare_model || r !== 2'b00) begin failures++; $display("FAIL alias_compare got=%h/%b want %h/00", d, r, compare_model); end
        axi_write(32'h10, 32'h7, 4'hF, r, a, q);
`ifdef AXIL_TIMER_PRESCALER_EN
        checks++; if (r !== 2'b00) begin failures++; $display("FAIL prescale_wr_resp got=%b want 00", r); end
        axi_read(32'h10, d, r, a);
        checks++; if (d !== 32'h7) begin failures++; $display("FAIL prescale_rd got=%h want 7", d); end
        axi_write(32'h10, 32'h0, 4'hF, r, a, q);
`else
        checks++; if (r !== 2'b10) begin failures++; $display("FAIL off10_wr_resp got=%b want 10", r); end
        axi_read(32'h10, d, r, a);
        checks++; if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL off10_rd got=%h/%b want 0/10", d, r); end
`endif
    endtask

    task automatic test_periodic();
        logic [31:0] d; logic [1:0] r; int acc, a, w; logic q, exp_irq;
        axi_write(32'h08, 32'd5, 4'hF, r, w, q);
        axi_write(32'h04, 32'd0, 4'hF, r, w, q);
        axi_write(32'h00, 32'h7, 4'hF, r, acc, q);
        while (cyc < acc + 6) begin
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL periodic_irq_early at=%0d got=%b want 0", cyc - acc, irq); end
            @(negedge aclk);
        end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL periodic_irq_rise got=%b want 1", irq); end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge aclk);
            axi_read(32'h04, d, r, a);
            checks++; if (d !== 32'((a - 1 - acc) % 6)) begin failures++; $display("FAIL periodic_count got=%0d want %0d", d, (a - 1 - acc) % 6); end
        end
        while (((cyc - acc) % 6) != 2) @(negedge aclk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_pre_irq got=%b want 1", irq); end
        axi_write(32'h0C, 32'h1, 4'hF, r, w, q);
        exp_irq = (((w - 1 - acc) % 6) == 5);
        checks++; if (q !== exp_irq) begin failures++; $display("FAIL w1c_drop got=%b want %b", q, exp_irq); end
        while (((cyc - acc) % 6) != 5) @(negedge aclk);
        axi_write(32'h0C, 32'h1, 4'hF, r, w, q);
        exp_irq = (((w - 1 - acc) % 6) == 5);
        checks++; if (q !== exp_irq || exp_irq !== 1'b1) begin failures++; $display("FAIL w1c_collision got=%b want 1", q); end
        axi_read(32'h0C, d, r, a);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL w1c_collision_status got=%h want 1", d); end
        axi_write(32'h00, 32'h0, 4'hF, r, w, q);
        axi_write(32'h0C, 32'h1, 4'hF, r, w, q);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL disable_irq got=%b want 0", irq); end
    endtask

    task automatic test_wrap();
        logic [31:0] d, e; logic [1:0] r; int acc, a, w; logic q;
        axi_write(32'h08, 32'h0, 4'hF, r, w, q);
        compare_model = 32'h0;
        axi_write(32'h04, 32'hFFFFFFFE, 4'hF, r, w, q);
        axi_write(32'h00, 32'h1, 4'hF, r, acc, q);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            axi_read(32'h04, d, r, a);
            e = 32'hFFFFFFFE + 32'(a - 1 - acc);
            checks++; if (d !== e) begin failures++; $display("FAIL wrap_count got=%h want %h", d, e); end
        end
        axi_read(32'h0C, d, r, a);
        e = ((a - 1 - acc) >= 3) ? 32'h1 : 32'h0;
        checks++; if (d !== e) begin failures++; $display("FAIL wrap_pending got=%h want %h", d, e); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL wrap_irq_masked got=%b want 0", irq); end
        axi_write(32'h00, 32'h0, 4'hF, r, w, q);
    endtask

    task automatic test_backpressure();
        logic [31:0] d, b_val; logic [1:0] r; int a, n; logic q;
        axi_write(32'h0C, 32'h1, 4'hF, r, a, q);
        axi_write(32'h00, 32'h6, 4'hF, r, a, q);
        b_val = $urandom;
        s_axil_bready = 1'b0;
        s_axil_awaddr = 32'h08; s_axil_wdata = $urandom; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1; n = 0;
        while (!s_axil_awready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL bp_wr_accept awready=%b want 1", s_axil_awready); end
        @(negedge aclk);
        s_axil_wdata = b_val;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_axil_bvalid !== 1'b1) begin failures++; $display("FAIL bp_bvalid_hold got=%b want 1", s_axil_bvalid); end
            checks++; if (s_axil_awready !== 1'b0) begin failures++; $display("FAIL bp_awready_blocked got=%b want 0", s_axil_awready); end
            checks++; if (s_axil_bresp !== 2'b00) begin failures++; $display("FAIL bp_bresp_stable got=%b want 00", s_axil_bresp); end
            @(negedge aclk); #1;
        end
        s_axil_bready = 1'b1;
        #1;
        checks++; if (s_axil_awready !== 1'b0) begin failures++; $display("FAIL bp_awready_on_bready got=%b want 0", s_axil_awready); end
        @(negedge aclk); #1;
        checks++; if (s_axil_awready !== 1'b1 || s_axil_bvalid !== 1'b0) begin failures++; $display("FAIL bp_second_accept awready=%b bvalid=%b want 1/0", s_axil_awready, s_axil_bvalid); end
        @(negedge aclk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        #1;
        checks++; if (s_axil_bvalid !== 1'b1) begin failures++; $display("FAIL bp_second_bvalid got=%b want 1", s_axil_bvalid); end
        @(negedge aclk);
        compare_model = b_val;
        s_axil_rready = 1'b0;
        s_axil_araddr = 32'h08; s_axil_arvalid = 1'b1;
        #1; n = 0;
        while (!s_axil_arready && n < 20) begin @(negedge aclk); #1; n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL bp_rd_accept arready=%b want 1", s_axil_arready); end
        @(negedge aclk);
        s_axil_araddr = 32'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_axil_rvalid !== 1'b1 || s_axil_arready !== 1'b0) begin failures++; $display("FAIL bp_rvalid_hold rvalid=%b arready=%b want 1/0", s_axil_rvalid, s_axil_arready); end
            checks++; if (s_axil_rdata !== compare_model || s_axil_rresp !== 2'b00) begin failures++; $display("FAIL bp_rdata_stable got=%h/%b want %h/00", s_axil_rdata, s_axil_rresp, compare_model); end
            @(negedge aclk); #1;
        end
        s_axil_rready = 1'b1;
        @(negedge aclk); #1;
        checks++; if (s_axil_arready !== 1'b1 || s_axil_rvalid !== 1'b0) begin failures++; $display("FAIL bp_rd_release arready=%b rvalid=%b want 1/0", s_axil_arready, s_axil_rvalid); end
        @(negedge aclk);
        s_axil_arvalid = 1'b0;
        #1;
        checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h6) begin failures++; $display("FAIL bp_second_read got=%b/%h want 1/6", s_axil_rvalid, s_axil_rdata); end
        @(negedge aclk);
        axi_write(32'h00, 32'h0, 4'hF, r, a, q);
    endtask

`ifdef AXIL_TIMER_PRESCALER_EN
    task automatic test_prescaler();
        logic [31:0] d; logic [1:0] r; int acc, a, w; logic q;
        axi_write(32'h10, 32'd3, 4'hF, r, w, q);
        axi_write(32'h08, 32'hFFFFFFFF, 4'hF, r, w, q);
        axi_write(32'h04, 32'd0, 4'hF, r, w, q);
        axi_write(32'h00, 32'h1, 4'hF, r, acc, q);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge aclk);
            axi_read(32'h04, d, r, a);
            checks++; if (d !== 32'((a - 1 - acc) / 4)) begin failures++; $display("FAIL prescale_count got=%0d want %0d", d, (a - 1 - acc) / 4); end
        end
        axi_write(32'h00, 32'h0, 4'hF, r, w, q);
    endtask
`endif

    initial begin
        test_reset();
        test_strobes();
        test_unmapped();
        test_periodic();
        test_wrap();
        test_backpressure();
`ifdef AXIL_TIMER_PRESCALER_EN
        test_prescaler();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
